// File: rtl/not_equal_pkg.sv
// Shared types and default constants for the not_equal_multi temporal comparator.
package not_equal_pkg;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        FIRE  = 2'd1,
        NEVER = 2'd2
    } state_e;

    localparam int DEF_N_CH              = 4;
    localparam int DEF_GAMMA_CYCLE_WIDTH = 16;
    localparam int DEF_PULSE_WIDTH       = 8;

endpackage

// File: rtl/gamma_counter.sv
// Free-running gamma-cycle counter: gstart marks gcnt==0, glast marks the final cycle.
module gamma_counter
    import not_equal_pkg::*;
#(
    parameter  int GAMMA_CYCLE_WIDTH = DEF_GAMMA_CYCLE_WIDTH,
    localparam int TW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic          aclk,
    input  logic          grst,
    output logic [TW-1:0] gcnt,
    output logic          gstart,
    output logic          glast
);

    logic [TW-1:0] gcnt_q;
    logic [TW-1:0] gcnt_d;

    assign glast  = (gcnt_q == TW'(GAMMA_CYCLE_WIDTH - 1));
    assign gstart = (gcnt_q == '0);
    assign gcnt   = gcnt_q;

    always_comb begin
        gcnt_d = glast ? '0 : gcnt_q + TW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (grst) begin
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end

endmodule

// File: rtl/not_equal_multi.sv
// Multi-input temporal "not equal": y fires after a unique earliest arrival, never on a tie.
// Define NOT_EQUAL_MULTI_PULSE_EN for a PULSE_WIDTH-long y pulse; default is level mode.
module not_equal_multi
    import not_equal_pkg::*;
#(
    parameter  int N_CH              = DEF_N_CH,
    parameter  int GAMMA_CYCLE_WIDTH = DEF_GAMMA_CYCLE_WIDTH,
    parameter  int PULSE_WIDTH       = DEF_PULSE_WIDTH,
    localparam int TW                = $clog2(GAMMA_CYCLE_WIDTH),
    localparam int IW                = $clog2(N_CH)
) (
    input  logic            aclk,
    input  logic            grst,
    input  logic [N_CH-1:0] a,
    output logic            gstart,
    output logic            y,
    output logic [TW-1:0]   y_time,
    output logic [IW-1:0]   y_idx
);

    if (N_CH < 2 || N_CH > 16 || GAMMA_CYCLE_WIDTH < 4 ||
        (GAMMA_CYCLE_WIDTH & (GAMMA_CYCLE_WIDTH - 1)) != 0 ||
        PULSE_WIDTH < 1 || PULSE_WIDTH > GAMMA_CYCLE_WIDTH - 1) begin : g_bad_params
        $error("not_equal_multi: parameter out of range");
    end

    logic [TW-1:0] gcnt;
    logic          glast;

    gamma_counter #(
        .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH)
    ) u_gamma_counter (
        .aclk   (aclk),
        .grst   (grst),
        .gcnt   (gcnt),
        .gstart (gstart),
        .glast  (glast)
    );

    state_e        state_q, state_d;
    logic          y_q, y_d;
    logic [TW-1:0] y_time_q, y_time_d;
    logic [IW-1:0] y_idx_q, y_idx_d;
    logic          any_hit;
    logic          one_hit;
    logic [IW-1:0] hit_idx;
    logic          fire;

    // In WAIT nothing has arrived yet, so every high input is a first arrival.
    assign any_hit = (a != '0);
    assign one_hit = any_hit && ((a & (a - N_CH'(1))) == '0);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (a[i]) begin
                hit_idx = IW'(i);
            end
        end
    end

`ifdef NOT_EQUAL_MULTI_PULSE_EN
    localparam logic [TW-1:0] PW = TW'(PULSE_WIDTH);
    logic [TW-1:0] pcnt_q, pcnt_d;
`endif

    always_comb begin
        state_d  = state_q;
        y_time_d = y_time_q;
        y_idx_d  = y_idx_q;
        fire     = 1'b0;

        if (glast) begin
            state_d = WAIT;
        end else begin
            case (state_q)
                WAIT: begin
                    if (one_hit) begin
                        state_d  = FIRE;
                        fire     = 1'b1;
                        y_time_d = gcnt;
                        y_idx_d  = hit_idx;
                    end else if (any_hit) begin
                        state_d = NEVER;
                    end
                end
                default: ;
            endcase
        end

`ifdef NOT_EQUAL_MULTI_PULSE_EN
        pcnt_d = pcnt_q;
        y_d    = y_q;
        if (glast) begin
            y_d    = 1'b0;
            pcnt_d = '0;
        end else if (fire) begin
            y_d    = 1'b1;
            pcnt_d = TW'(1);
        end else if (y_q) begin
            if (pcnt_q == PW) begin
                y_d    = 1'b0;
                pcnt_d = '0;
            end else begin
                pcnt_d = pcnt_q + TW'(1);
            end
        end
`else
        y_d = (state_d == FIRE);
`endif

        // Result fields read zero whenever y is low.
        if (!y_d) begin
            y_time_d = '0;
            y_idx_d  = '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (grst) begin
            state_q  <= WAIT;
            y_q      <= 1'b0;
            y_time_q <= '0;
            y_idx_q  <= '0;
`ifdef NOT_EQUAL_MULTI_PULSE_EN
            pcnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            y_time_q <= y_time_d;
            y_idx_q  <= y_idx_d;
`ifdef NOT_EQUAL_MULTI_PULSE_EN
            pcnt_q   <= pcnt_d;
`endif
        end
    end

    assign y      = y_q;
    assign y_time = y_time_q;
    assign y_idx  = y_idx_q;

endmodule

// File: tb/tb_not_equal_multi.sv
// Directed self-checking bench for not_equal_multi (N_CH=4, gamma=16, pulse width 8).
module tb_not_equal_multi;

    localparam int GW = 16;
    localparam int PW = 8;

    logic       aclk;
    logic       grst;
    logic [3:0] a;
    logic       gstart;
    logic       y;
    logic [3:0] y_time;
    logic [1:0] y_idx;

    int tests;
    int fails;

    not_equal_multi dut (
        .aclk   (aclk),
        .grst   (grst),
        .a      (a),
        .gstart (gstart),
        .y      (y),
        .y_time (y_time),
        .y_idx  (y_idx)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Last gamma-cycle index at which y is still high, given the cycle y rises.
    function automatic int fall_of(input int rise);
`ifdef NOT_EQUAL_MULTI_PULSE_EN
        return (rise + PW - 1 > GW - 1) ? GW - 1 : rise + PW - 1;
`else
        return GW - 1;
`endif
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        grst = 1'b1;
        a    = '0;
        repeat (3) step();
        tests++;
        if (y !== 1'b0 || y_time !== 4'd0 || y_idx !== 2'd0 || gstart !== 1'b1) begin
            fails++;
            $display("FAIL reset: y=%b y_time=%0d y_idx=%0d gstart=%b, expected 0 0 0 1",
                     y, y_time, y_idx, gstart);
        end
        grst = 1'b0;
    endtask

    task automatic test_idle();
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < GW; k++) begin
                tests++;
                if (y !== 1'b0 || y_time !== 4'd0 || gstart !== (k == 0)) begin
                    fails++;
                    $display("FAIL idle g=%0d k=%0d: y=%b y_time=%0d gstart=%b, expected y=0 y_time=0 gstart=%b",
                             g, k, y, y_time, gstart, (k == 0));
                end
                a = '0;
                step();
            end
        end
    endtask

    task automatic test_unique();
        logic       ey;
        logic [3:0] et;
        logic [1:0] ei;
        for (int k = 0; k < GW; k++) begin
            ey = (k >= 4 && k <= fall_of(4));
            et = ey ? 4'd3 : 4'd0;
            ei = ey ? 2'd2 : 2'd0;
            tests++;
            if (y !== ey || y_time !== et || y_idx !== ei || gstart !== (k == 0)) begin
                fails++;
                $display("FAIL unique k=%0d: y=%b y_time=%0d y_idx=%0d gstart=%b, expected y=%b y_time=%0d y_idx=%0d gstart=%b",
                         k, y, y_time, y_idx, gstart, ey, et, ei, (k == 0));
            end
            a    = '0;
            a[2] = (k >= 3 && k < GW - 1);
            a[0] = (k >= 5 && k < GW - 1);
            step();
        end
    endtask

    task automatic test_tie();
        for (int k = 0; k < GW; k++) begin
            tests++;
            if (y !== 1'b0 || y_time !== 4'd0 || y_idx !== 2'd0) begin
                fails++;
                $display("FAIL tie k=%0d: y=%b y_time=%0d y_idx=%0d, expected 0 0 0",
                         k, y, y_time, y_idx);
            end
            a    = '0;
            a[1] = (k >= 2 && k < GW - 1);
            a[3] = (k >= 2 && k < GW - 1);
            a[0] = (k >= 6 && k < GW - 1);
            step();
        end
    endtask

    task automatic test_t0_and_last();
        logic ey;
        for (int k = 0; k < GW; k++) begin
            ey = (k >= 1 && k <= fall_of(1));
            tests++;
            if (y !== ey || y_time !== 4'd0 || y_idx !== 2'd0) begin
                fails++;
                $display("FAIL t0 k=%0d: y=%b y_time=%0d y_idx=%0d, expected y=%b y_time=0 y_idx=0",
                         k, y, y_time, y_idx, ey);
            end
            a    = '0;
            a[0] = (k < GW - 1);
            step();
        end
        // Next gamma: a[1] appears only in the last cycle and must be ignored.
        for (int k = 0; k < GW + 1; k++) begin
            tests++;
            if (y !== 1'b0 || y_time !== 4'd0 || y_idx !== 2'd0) begin
                fails++;
                $display("FAIL last_ignored k=%0d: y=%b y_time=%0d y_idx=%0d, expected 0 0 0",
                         k, y, y_time, y_idx);
            end
            a    = '0;
            a[1] = (k == GW - 1);
            if (k < GW) step();
        end
        // Re-align: the extra check above sat at k=0 of a fresh gamma cycle.
        for (int k = 0; k < GW; k++) begin
            a = '0;
            step();
        end
    endtask

    task automatic test_late();
        logic       ey;
        logic [3:0] et;
        logic [1:0] ei;
        for (int k = 0; k < GW + 1; k++) begin
            ey = (k >= 13 && k <= GW - 1);
            et = ey ? 4'd12 : 4'd0;
            ei = ey ? 2'd3 : 2'd0;
            tests++;
            if (y !== ey || y_time !== et || y_idx !== ei || gstart !== (k % GW == 0)) begin
                fails++;
                $display("FAIL late k=%0d: y=%b y_time=%0d y_idx=%0d gstart=%b, expected y=%b y_time=%0d y_idx=%0d gstart=%b",
                         k, y, y_time, y_idx, gstart, ey, et, ei, (k % GW == 0));
            end
            a    = '0;
            a[3] = (k >= 12 && k < GW - 1);
            if (k < GW) step();
        end
    endtask

    task automatic test_mid_reset();
        logic ey;
        // Enter at k=0 of a gamma cycle.
        for (int k = 0; k < 8; k++) begin
            ey = (k >= 3);
            tests++;
            if (y !== ey || y_time !== (ey ? 4'd2 : 4'd0) || y_idx !== (ey ? 2'd1 : 2'd0)) begin
                fails++;
                $display("FAIL mid_pre k=%0d: y=%b y_time=%0d y_idx=%0d, expected y=%b y_time=%0d y_idx=%0d",
                         k, y, y_time, y_idx, ey, (ey ? 2 : 0), (ey ? 1 : 0));
            end
            if (k == 7) begin
                grst = 1'b1;
                a    = '0;
            end else begin
                a    = '0;
                a[1] = (k >= 2);
            end
            step();
        end
        tests++;
        if (y !== 1'b0 || y_time !== 4'd0 || y_idx !== 2'd0 || gstart !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset: y=%b y_time=%0d y_idx=%0d gstart=%b, expected 0 0 0 1",
                     y, y_time, y_idx, gstart);
        end
        grst = 1'b0;
        step();
        for (int k = 1; k < GW + 1; k++) begin
            tests++;
            if (y !== 1'b0 || gstart !== (k == GW)) begin
                fails++;
                $display("FAIL mid_post k=%0d: y=%b gstart=%b, expected y=0 gstart=%b",
                         k, y, gstart, (k == GW));
            end
            a = '0;
            if (k < GW) step();
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        grst  = 1'b1;
        a     = '0;
        test_reset();
        test_idle();
        test_unique();
        test_tie();
        test_t0_and_last();
        test_late();
        // test_late ends at k=0 of a new gamma cycle, as test_mid_reset expects.
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/not_equal_multi.md
NOT_EQUAL_MULTI -- requirements
Module: not_equal_multi

Interface
REQ-001 Parameter N_CH, default 4: number of input channels (2..16).
REQ-002 Parameter GAMMA_CYCLE_WIDTH, default 16: aclk cycles per gamma cycle (power of two, >=4).
REQ-003 Parameter PULSE_WIDTH, default 8: output pulse length in pulse mode (1..GAMMA_CYCLE_WIDTH-1).
REQ-004 Local parameter TW = $clog2(GAMMA_CYCLE_WIDTH): time-field width.
REQ-005 aclk  input  1  single clock; all state updates on its rising edge.
REQ-006 grst  input  1  reset, synchronous and active-high.
REQ-007 a  input  N_CH  per-channel temporal input; arrival = first cycle sampled high in current gamma cycle.
REQ-008 gstart  output  1  high during the first cycle of each gamma cycle (gcnt==0).
REQ-009 y  output  1  temporal result; rises one cycle after a unique earliest arrival.
REQ-010 y_time  output  TW  gcnt value of the winning arrival; valid while y high.
REQ-011 y_idx  output  $clog2(N_CH)  index of the winning channel; valid while y high.

Function
REQ-012 Gamma counter gcnt counts 0..GAMMA_CYCLE_WIDTH-1 and wraps to 0; gstart = (gcnt==0).
REQ-013 Arrival: channel i arrives in the first cycle of the gamma cycle with a[i]==1; a channel already high at gcnt==0 arrives at t=0.
REQ-014 FSM states WAIT, FIRE, NEVER; every gamma cycle begins in WAIT.
REQ-015 WAIT -> FIRE when exactly one channel arrives in a cycle with no prior arrival; capture y_time=gcnt, y_idx=i.
REQ-016 WAIT -> NEVER when two or more channels arrive in the same first-arrival cycle (tie = equal, output is infinity).
REQ-017 Arrivals after the first-arrival cycle shall not change state, y_time or y_idx.
REQ-018 Arrivals sampled at gcnt==GAMMA_CYCLE_WIDTH-1 are ignored (treated as infinity).
REQ-019 Any state -> WAIT on the cycle after gcnt==GAMMA_CYCLE_WIDTH-1; y deasserts that cycle.
REQ-020 y is registered: arrival sampled at gcnt=t gives y high from gcnt=t+1.
REQ-021 y_time and y_idx read 0 whenever y is low.
REQ-022 No arrival in a gamma cycle: FSM stays WAIT, y stays 0.

Reset
REQ-023 grst high at a rising edge sets gcnt=0, FSM=WAIT, y=0, y_time=0, y_idx=0, pulse counter=0.
REQ-024 First cycle after grst release is gcnt==0 (gstart=1).
REQ-025 grst mid-gamma aborts the current comparison; no y pulse spans reset.

Configuration
REQ-026 Macro NOT_EQUAL_MULTI_PULSE_EN defined: y stays high for PULSE_WIDTH cycles after rising, or until gamma end, whichever is first.
REQ-027 Macro undefined: y stays high from rise through gcnt==GAMMA_CYCLE_WIDTH-1 (level mode); no pulse counter synthesised.

Structure
REQ-028 Package not_equal_pkg holds the FSM state enum (WAIT/FIRE/NEVER) and default parameter constants.
REQ-029 Sub-module gamma_counter (aclk, grst -> gcnt, gstart, glast) is instantiated once; the rest is in not_equal_multi.

Verification (N_CH=4, GAMMA=16, PULSE_WIDTH=8)
REQ-030 No input high for a full gamma cycle -> y=0 throughout; gstart pulses every 16 cycles.
REQ-031 a[2] rises at gcnt=3, a[0] at gcnt=5 -> y high gcnt 4..15 (level) or 4..11 (pulse); y_time=3, y_idx=2.
REQ-032 a[1] and a[3] rise together at gcnt=2, a[0] at gcnt=6 -> NEVER, y=0 all gamma cycle.
REQ-033 a[0] high at gcnt=0 -> y high from gcnt=1, y_time=0, y_idx=0; a[1] rises at gcnt=15 alone in the next gamma -> ignored, y=0.
REQ-034 a[3] rises at gcnt=12, pulse mode -> y high gcnt 13..15 only (truncated at gamma end); next gamma starts in WAIT with y=0.
REQ-035 grst asserted at gcnt=7 while y high -> next cycle y=0, y_time=0, gcnt=0 and gstart=1 after release.
